multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle control FSM for the MIPS core. Sequences one shared ALU, one unified memory
//  port and the register file over 3-5 cycles per instruction (lw, sw, R-type, addi, beq, j).
//  Waits on a memory ready handshake with a timeout, and counts retired instructions.
//  Sits between the instruction register (opcode/funct) and the datapath muxes and enables.
// PARAMETERS
//  CNT_W    32  width of the retired-instruction counter
//  TIMEOUT  16  max cycles a memory access waits for mem_ready before abort (>=2)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  opcode       in   6      IR[31:26]; stable from DECODE until the next FETCH
//  funct        in   6      IR[5:0]
//  mem_ready    in   1      memory has completed the access requested this cycle
//  mem_req      out  1      memory access request; held until mem_ready or abort
//  mem_wrt      out  1      write strobe, qualified by mem_req
//  i_or_d       out  1      0: address = PC, 1: address = ALUOut
//  ir_wrt       out  1      load IR
//  pc_wrt       out  1      unconditional PC load
//  pc_wrt_cond  out  1      PC load if ALU zero (beq)
//  pc_src       out  2      00 ALU result, 01 ALUOut, 10 jump target
//  ALUsrcA      out  1      0 PC, 1 rs
//  ALUsrcB      out  2      00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  ALU_control  out  3      010 add, 100 sub, 110 slt, 101 mul
//  reg_des      out  1      0 rt, 1 rd
//  mem_to_reg   out  1      0 ALUOut, 1 MDR
//  reg_wrt      out  1      register file write enable
//  illegal_op   out  1      1-cycle pulse when DECODE sees an unsupported opcode
//  bus_err      out  1      1-cycle pulse on memory timeout
//  instr_count  out  CNT_W  retired instruction count; wraps modulo 2^CNT_W
// BEHAVIOUR
//  State register (4 bit): IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC,
//  ADDI_EXEC, ALU_WB, BRANCH, JUMP. Outputs are Moore (decoded from the state) except those
//  gated by mem_ready. Any output not listed for a state is 0; ALU_control defaults to 010.
//  Reset: state=IDLE, wait_cnt=0, instr_count=0, illegal_op=bus_err=0, every output 0.
//  Reset is honoured mid-instruction and aborts it with no further write strobes.
//  IDLE: all outputs 0 -> FETCH on the next clock.
//  FETCH: mem_req, i_or_d=0, ALUsrcA=0, ALUsrcB=01, add, pc_src=00. ir_wrt and pc_wrt are
//   asserted only in the cycle mem_ready=1, which moves to DECODE; otherwise stay in FETCH.
//  DECODE: ALUsrcA=0, ALUsrcB=11, add (branch target into ALUOut).
//   Next state by opcode: 100011/101011 -> MEM_ADDR, 000000 -> R_EXEC, 001000 -> ADDI_EXEC,
//   000100 -> BRANCH, 000010 -> JUMP. Any other opcode -> FETCH, illegal_op=1 next cycle,
//   instruction not counted.
//  MEM_ADDR: ALUsrcA=1, ALUsrcB=10, add. Next MEM_RD (lw) or MEM_WR (sw).
//  MEM_RD: mem_req, i_or_d=1. mem_ready -> MEM_WB.
//  MEM_WB: reg_wrt, reg_des=0, mem_to_reg=1 -> FETCH.
//  MEM_WR: mem_req, mem_wrt, i_or_d=1. mem_ready -> FETCH.
//  R_EXEC: ALUsrcA=1, ALUsrcB=00. ALU_control by funct: 100000 add, 100010 sub,
//   101010 slt, 011100 mul, any other funct add. -> ALU_WB.
//  ADDI_EXEC: ALUsrcA=1, ALUsrcB=10, add -> ALU_WB.
//  ALU_WB: reg_wrt, mem_to_reg=0, reg_des=(opcode==000000) -> FETCH.
//  BRANCH: ALUsrcA=1, ALUsrcB=00, sub, pc_wrt_cond, pc_src=01 -> FETCH.
//  JUMP: pc_wrt, pc_src=10 -> FETCH.
//  Retire: instr_count+1 on each transition into FETCH from MEM_WB, MEM_WR (on mem_ready),
//   ALU_WB, BRANCH or JUMP. Aborted or illegal instructions are never counted.
//  Timeout: wait_cnt clears on entry to FETCH, MEM_RD or MEM_WR, and increments each cycle
//   mem_ready=0 in those states. When wait_cnt=TIMEOUT-1 and mem_ready=0, the state goes
//   to FETCH, bus_err pulses for 1 cycle and no write strobe is asserted. A timeout in FETCH
//   refetches the same PC. mem_ready=1 in the timeout cycle wins (the access completes).
// TESTING
//  1. Reset with rst_n=0 for 3 cycles, release -> 1 IDLE cycle with all outputs 0, then FETCH
//     with mem_req=1, i_or_d=0.
//  2. lw (opcode 100011), mem_ready=1 immediately -> FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB;
//     reg_wrt=1 and mem_to_reg=1 only in MEM_WB; instr_count 0->1.
//  3. R-type funct 011100 -> ALU_control=101 in R_EXEC; ALU_WB has reg_des=1;
//     funct 000111 -> ALU_control=010.
//  4. beq (000100) then j (000010) -> BRANCH: pc_wrt_cond=1, pc_src=01, ALU_control=100;
//     JUMP: pc_wrt=1, pc_src=10; instr_count +2.
//  5. sw with mem_ready=0 held, TIMEOUT=16 -> 16 cycles in MEM_WR, bus_err pulse, return to
//     FETCH, instr_count unchanged; mem_ready=1 on cycle 16 instead -> normal retire.
//  6. opcode 111111 -> illegal_op pulse, FETCH, no reg_wrt; rst_n=0 during MEM_RD ->
//     IDLE at once, all outputs 0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the MIPS datapath/memory.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_wrt;
  logic             i_or_d;
  logic             ir_wrt;
  logic             pc_wrt;
  logic             pc_wrt_cond;
  logic [1:0]       pc_src;
  logic             ALUsrcA;
  logic [1:0]       ALUsrcB;
  logic [2:0]       ALU_control;
  logic             reg_des;
  logic             mem_to_reg;
  logic             reg_wrt;
  logic             illegal_op;
  logic             bus_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, mem_ready,
    output mem_req, mem_wrt, i_or_d, ir_wrt, pc_wrt, pc_wrt_cond, pc_src,
           ALUsrcA, ALUsrcB, ALU_control, reg_des, mem_to_reg, reg_wrt,
           illegal_op, bus_err, instr_count
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  mem_req, mem_wrt, i_or_d, ir_wrt, pc_wrt, pc_wrt_cond, pc_src,
           ALUsrcA, ALUsrcB, ALU_control, reg_des, mem_to_reg, reg_wrt,
           illegal_op, bus_err, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences ALU, unified memory and register file,
// with a bounded wait on memory and a retired-instruction counter.
module multicycle_controller #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus,
  output logic [3:0]             o_state
);

  // Memory handshake: mem_req is held each cycle until the cycle mem_ready=1
  // (access done, FSM advances) or the wait budget expires (request dropped).
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_ADDI_EXEC = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  localparam int              WAIT_W   = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]   r_count;
  logic               r_illegal;
  logic               r_bus_err;
  logic               w_waiting;
  logic               w_timeout;
  logic               w_enter_wait;
  logic               w_illegal;
  logic               w_retire;

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout = w_waiting && !bus.mem_ready && (r_wait_cnt == WAIT_MAX);

  // A timeout in FETCH re-enters FETCH, which must also restart the wait budget.
  assign w_enter_wait = ((w_next == S_FETCH) || (w_next == S_MEM_RD) || (w_next == S_MEM_WR)) &&
                        ((w_next != r_state) || w_timeout);

  assign o_state         = r_state;
  assign bus.instr_count = r_count;
  assign bus.illegal_op  = r_illegal;
  assign bus.bus_err     = r_bus_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_count    <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal;
      r_bus_err <= w_timeout;
      if (w_retire) r_count <= r_count + 1'b1;
      if (w_enter_wait) r_wait_cnt <= '0;
      else if (w_waiting && !bus.mem_ready) r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_illegal       = 1'b0;
    w_retire        = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_wrt     = 1'b0;
    bus.i_or_d      = 1'b0;
    bus.ir_wrt      = 1'b0;
    bus.pc_wrt      = 1'b0;
    bus.pc_wrt_cond = 1'b0;
    bus.pc_src      = 2'b00;
    bus.ALUsrcA     = 1'b0;
    bus.ALUsrcB     = 2'b00;
    bus.ALU_control = ALU_ADD;
    bus.reg_des     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_wrt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.ALU_control = 3'b000;
        w_next          = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_req = !w_timeout;
        bus.ALUsrcB = 2'b01;
        if (bus.mem_ready) begin
          bus.ir_wrt = 1'b1;
          bus.pc_wrt = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.ALUsrcB = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_R:         w_next = S_R_EXEC;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUsrcB = 2'b10;
        w_next      = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.mem_req = !w_timeout;
        bus.i_or_d  = 1'b1;
        if (bus.mem_ready) w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEM_WB: begin
        bus.reg_wrt    = 1'b1;
        bus.mem_to_reg = 1'b1;
        w_next         = S_FETCH;
        w_retire       = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_req = !w_timeout;
        bus.mem_wrt = !w_timeout;
        bus.i_or_d  = 1'b1;
        if (bus.mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_timeout) begin
          w_next = S_FETCH;
        end
      end
      S_R_EXEC: begin
        bus.ALUsrcA = 1'b1;
        case (bus.funct)
          6'b100010: bus.ALU_control = ALU_SUB;
          6'b101010: bus.ALU_control = ALU_SLT;
          6'b011100: bus.ALU_control = ALU_MUL;
          default:   bus.ALU_control = ALU_ADD;
        endcase
        w_next = S_ALU_WB;
      end
      S_ADDI_EXEC: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUsrcB = 2'b10;
        w_next      = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_wrt = 1'b1;
        bus.reg_des = (bus.opcode == OP_R);
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUsrcA     = 1'b1;
        bus.ALU_control = ALU_SUB;
        bus.pc_wrt_cond = 1'b1;
        bus.pc_src      = 2'b01;
        w_next          = S_FETCH;
        w_retire        = 1'b1;
      end
      S_JUMP: begin
        bus.pc_wrt = 1'b1;
        bus.pc_src = 2'b10;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      default: begin
        bus.ALU_control = 3'b000;
        w_next          = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class, the
// memory timeout, illegal opcode and mid-instruction reset against hand-built vectors.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] o_state;
  int         n_checks;
  int         n_errors;

  multicycle_controller_if #(.CNT_W(32)) bus ();

  multicycle_controller #(.CNT_W(32), .TIMEOUT(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {mem_req, mem_wrt, i_or_d, ir_wrt, pc_wrt, pc_wrt_cond,
  // pc_src[1:0], ALUsrcA, ALUsrcB[1:0], ALU_control[2:0], reg_des, mem_to_reg,
  // reg_wrt, illegal_op, bus_err}
  function automatic logic [18:0] pk(logic mreq, logic mwrt, logic iord, logic irw,
                                     logic pcw, logic pcc, logic [1:0] pcsrc, logic asa,
                                     logic [1:0] asb, logic [2:0] alu, logic rdes,
                                     logic m2r, logic rw, logic ill, logic berr);
    return {mreq, mwrt, iord, irw, pcw, pcc, pcsrc, asa, asb, alu, rdes, m2r, rw, ill, berr};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {bus.mem_req, bus.mem_wrt, bus.i_or_d, bus.ir_wrt, bus.pc_wrt, bus.pc_wrt_cond,
            bus.pc_src, bus.ALUsrcA, bus.ALUsrcB, bus.ALU_control, bus.reg_des,
            bus.mem_to_reg, bus.reg_wrt, bus.illegal_op, bus.bus_err};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [3:0] st, input logic [18:0] vec);
    check_eq({tag, "_state"}, {28'd0, o_state}, {28'd0, st});
    check_eq({tag, "_ctl"}, {13'd0, dut_vec()}, {13'd0, vec});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [18:0] v_fetch, v_fetch_go, v_decode, v_addr, v_rd, v_wb, v_wr, v_wr_to;
  logic [18:0] v_rexec_mul, v_rexec_add, v_aluwb_r, v_aluwb_i, v_branch, v_jump;
  logic [18:0] v_fetch_berr, v_fetch_ill;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    v_fetch       = pk(1,0,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0,0);
    v_fetch_go    = pk(1,0,0,1,1,0,2'b00,0,2'b01,3'b010,0,0,0,0,0);
    v_decode      = pk(0,0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,0,0);
    v_addr        = pk(0,0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0,0);
    v_rd          = pk(1,0,1,0,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,0);
    v_wb          = pk(0,0,0,0,0,0,2'b00,0,2'b00,3'b010,0,1,1,0,0);
    v_wr          = pk(1,1,1,0,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,0);
    v_wr_to       = pk(0,0,1,0,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,0);
    v_rexec_mul   = pk(0,0,0,0,0,0,2'b00,1,2'b00,3'b101,0,0,0,0,0);
    v_rexec_add   = pk(0,0,0,0,0,0,2'b00,1,2'b00,3'b010,0,0,0,0,0);
    v_aluwb_r     = pk(0,0,0,0,0,0,2'b00,0,2'b00,3'b010,1,0,1,0,0);
    v_aluwb_i     = pk(0,0,0,0,0,0,2'b00,0,2'b00,3'b010,0,0,1,0,0);
    v_branch      = pk(0,0,0,0,0,1,2'b01,1,2'b00,3'b100,0,0,0,0,0);
    v_jump        = pk(0,0,0,0,1,0,2'b10,0,2'b00,3'b010,0,0,0,0,0);
    v_fetch_berr  = pk(1,0,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0,1);
    v_fetch_ill   = pk(1,0,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,1,0);

    rst_n         = 1'b0;
    bus.opcode    = 6'b000000;
    bus.funct     = 6'b000000;
    bus.mem_ready = 1'b0;

    // Reset and the single IDLE cycle
    repeat (3) step();
    check_st("in_reset", 4'd0, 19'd0);
    check_eq("in_reset_cnt", bus.instr_count, 32'd0);
    rst_n = 1'b1;
    #1;
    check_st("idle", 4'd0, 19'd0);
    step();
    check_st("fetch_wait", 4'd1, v_fetch);

    // lw with immediate mem_ready
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'b100011;
    #1;
    check_st("lw_fetch", 4'd1, v_fetch_go);
    step(); check_st("lw_decode", 4'd2, v_decode);
    step(); check_st("lw_addr", 4'd3, v_addr);
    step(); check_st("lw_rd", 4'd4, v_rd);
    step(); check_st("lw_wb", 4'd5, v_wb);
    check_eq("lw_cnt_before", bus.instr_count, 32'd0);
    step(); check_st("lw_done", 4'd1, v_fetch_go);
    check_eq("lw_cnt", bus.instr_count, 32'd1);

    // R-type mul, then an unknown funct defaults to add
    bus.opcode = 6'b000000;
    bus.funct  = 6'b011100;
    step(); check_st("mul_decode", 4'd2, v_decode);
    step(); check_st("mul_exec", 4'd7, v_rexec_mul);
    step(); check_st("mul_wb", 4'd9, v_aluwb_r);
    step(); check_eq("mul_cnt", bus.instr_count, 32'd2);
    bus.funct = 6'b000111;
    step(); check_st("dflt_decode", 4'd2, v_decode);
    step(); check_st("dflt_exec", 4'd7, v_rexec_add);
    step(); check_st("dflt_wb", 4'd9, v_aluwb_r);
    step(); check_eq("dflt_cnt", bus.instr_count, 32'd3);

    // beq then j
    bus.opcode = 6'b000100;
    step(); check_st("beq_decode", 4'd2, v_decode);
    step(); check_st("beq_branch", 4'd10, v_branch);
    step(); check_eq("beq_cnt", bus.instr_count, 32'd4);
    bus.opcode = 6'b000010;
    step(); check_st("j_decode", 4'd2, v_decode);
    step(); check_st("j_jump", 4'd11, v_jump);
    step(); check_eq("j_cnt", bus.instr_count, 32'd5);

    // addi writes rt
    bus.opcode = 6'b001000;
    step(); check_st("addi_decode", 4'd2, v_decode);
    step(); check_st("addi_exec", 4'd8, v_addr);
    step(); check_st("addi_wb", 4'd9, v_aluwb_i);
    step(); check_eq("addi_cnt", bus.instr_count, 32'd6);

    // sw with mem_ready held low: 16 cycles in MEM_WR then abort
    bus.opcode = 6'b101011;
    step(); check_st("sw_decode", 4'd2, v_decode);
    step(); check_st("sw_addr", 4'd3, v_addr);
    bus.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      check_st($sformatf("sw_wait%0d", i), 4'd6, v_wr);
      step();
    end
    check_st("sw_timeout", 4'd6, v_wr_to);
    step();
    check_st("sw_berr", 4'd1, v_fetch_berr);
    check_eq("sw_to_cnt", bus.instr_count, 32'd6);
    step();
    check_st("berr_clear", 4'd1, v_fetch);

    // sw where mem_ready arrives in the 16th cycle
    bus.mem_ready = 1'b1;
    step(); check_st("sw2_decode", 4'd2, v_decode);
    step(); check_st("sw2_addr", 4'd3, v_addr);
    bus.mem_ready = 1'b0;
    repeat (16) step();
    bus.mem_ready = 1'b1;
    #1;
    check_st("sw2_last", 4'd6, v_wr);
    step();
    check_st("sw2_done", 4'd1, v_fetch_go);
    check_eq("sw2_cnt", bus.instr_count, 32'd7);

    // illegal opcode
    bus.opcode = 6'b111111;
    step(); check_st("ill_decode", 4'd2, v_decode);
    bus.mem_ready = 1'b0;
    step(); check_st("ill_pulse", 4'd1, v_fetch_ill);
    check_eq("ill_cnt", bus.instr_count, 32'd7);

    // lw aborted by reset in MEM_RD
    bus.opcode    = 6'b100011;
    bus.mem_ready = 1'b1;
    step(); check_st("abort_decode", 4'd2, v_decode);
    step(); check_st("abort_addr", 4'd3, v_addr);
    bus.mem_ready = 1'b0;
    step(); check_st("abort_rd", 4'd4, v_rd);
    #3;
    rst_n = 1'b0;
    #1;
    check_st("abort_reset", 4'd0, 19'd0);
    check_eq("abort_cnt", bus.instr_count, 32'd0);
    step();
    check_st("abort_hold", 4'd0, 19'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
